seq_mul: RTL

- Parametrised, multi-cycle shift-add multiplier for the CPU execute stage; replaces the single-shot N-bit multiplier.
- Supports signed and unsigned operands per operation and uses a start/busy/done handshake.
- Returns a full 2N-bit product.
- One operation in flight at a time. The result holds until the next result overwrites it.

---
 rtl/seq_mul_pkg.sv | 17 +
 rtl/seq_mul_abs.sv | 12 +
 rtl/seq_mul.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the seq_mul shift-add multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int SEQ_MUL_N_DEFAULT = 16;

    // Iteration counter must hold the value N itself.
    function automatic int seq_mul_cw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_mul_abs.sv
// Conditional two's-complement negate: y = en ? -x : x.
module seq_mul_abs #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic         en,
    output logic [W-1:0] y
);

    assign y = en ? (-x) : x;

endmodule

// File: rtl/seq_mul.sv
// Multi-cycle signed/unsigned shift-add multiplier with start/busy/done handshake.
// Optional SEQ_MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are zero.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int N = SEQ_MUL_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           is_signed,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = seq_mul_cw(N);

    state_t           state_reg, state_next;
    logic [N-1:0]     mcand_reg, mcand_next;
    logic [N-1:0]     mplier_reg, mplier_next;
    logic             neg_reg, neg_next;
    logic [2*N-1:0]   acc_reg, acc_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             done_reg, done_next;
    logic [2*N-1:0]   product_reg, product_next;

    logic [N-1:0]     a_mag, b_mag;
    logic [2*N-1:0]   acc_fixed;
    logic [N-1:0]     mplier_shift;
    logic [CW-1:0]    shamt;
    logic [2*N-1:0]   addend;

    seq_mul_abs #(.W(N)) u_abs_a (
        .x  (a),
        .en (is_signed & a[N-1]),
        .y  (a_mag)
    );

    seq_mul_abs #(.W(N)) u_abs_b (
        .x  (b),
        .en (is_signed & b[N-1]),
        .y  (b_mag)
    );

    // Sign is reapplied once at the end; -0 naturally stays 0.
    seq_mul_abs #(.W(2*N)) u_abs_p (
        .x  (acc_reg),
        .en (neg_reg),
        .y  (acc_fixed)
    );

    assign mplier_shift = mplier_reg >> 1;
    assign shamt        = CW'(N) - cnt_reg;
    assign addend       = {{N{1'b0}}, mcand_reg} << shamt;

    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        neg_next     = neg_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        done_next    = 1'b0;
        product_next = product_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    mcand_next  = a_mag;
                    mplier_next = b_mag;
                    neg_next    = is_signed & (a[N-1] ^ b[N-1]);
                    acc_next    = '0;
                    cnt_next    = CW'(N);
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (mplier_reg[0]) begin
                    acc_next = acc_reg + addend;
                end
                mplier_next = mplier_shift;
                cnt_next    = cnt_reg - CW'(1);
`ifdef SEQ_MUL_EARLY_TERM_EN
                if ((cnt_reg == CW'(1)) || (mplier_shift == '0)) begin
                    state_next = FIX;
                end
`else
                if (cnt_reg == CW'(1)) begin
                    state_next = FIX;
                end
`endif
            end
            FIX: begin
                product_next = acc_fixed;
                done_next    = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            neg_reg     <= 1'b0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            neg_reg     <= neg_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            done_reg    <= done_next;
            product_reg <= product_next;
        end
    end

    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign product = product_reg;

endmodule
